// File: rtl/booth_mac_accumulator.sv
// Streaming MAC stage: sums blocks of signed Booth products into a wide accumulator
// and presents each finished block sum in a registered valid/ready output slot.
module booth_mac_accumulator #(
    parameter int PW    = 65,
    parameter int AW    = 72,
    parameter int BLOCK = 8,
    parameter int CW    = $clog2(BLOCK+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prod_valid,
    input  logic [PW-1:0] prod,
    input  logic          prod_last,
    output logic          prod_ready,
    output logic          acc_valid,
    output logic [AW-1:0] acc_out,
    output logic [CW-1:0] acc_terms,
    output logic          acc_ovf,
    input  logic          acc_ready
);

    if (AW < PW) begin : g_bad_aw
        $error("booth_mac_accumulator: AW must be >= PW");
    end
    if (BLOCK < 1) begin : g_bad_block
        $error("booth_mac_accumulator: BLOCK must be >= 1");
    end

    typedef struct packed {
        logic [AW-1:0] sum;
        logic [CW-1:0] terms;
        logic          ovf;
    } acc_res_t;

    logic [AW-1:0] sum;
    logic [CW-1:0] cnt;
    logic          ovf_run;

    logic [AW-1:0] pext;
    logic [AW-1:0] nsum;
    logic          ovf_beat;
    logic          last_beat;
    logic          take;
    logic          drain;
    acc_res_t      res;

    assign pext = AW'($signed(prod));
    assign nsum = sum + pext;

    // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
    assign ovf_beat  = (sum[AW-1] == pext[AW-1]) && (nsum[AW-1] != sum[AW-1]);
    assign last_beat = prod_last || (cnt == CW'(BLOCK-1));

    // The output slot is refilled on the same edge it drains, so a ready sink
    // never sees a bubble between consecutive block results.
    assign prod_ready = !acc_valid || acc_ready;
    assign take       = prod_valid && prod_ready;
    assign drain      = acc_valid && acc_ready;

    assign res.sum   = nsum;
    assign res.terms = cnt + CW'(1);
    assign res.ovf   = ovf_run | ovf_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cnt       <= '0;
            ovf_run   <= 1'b0;
            acc_valid <= 1'b0;
            acc_out   <= '0;
            acc_terms <= '0;
            acc_ovf   <= 1'b0;
        end else begin
            if (take) begin
                if (last_beat) begin
                    acc_out   <= res.sum;
                    acc_terms <= res.terms;
                    acc_ovf   <= res.ovf;
                    sum       <= '0;
                    cnt       <= '0;
                    ovf_run   <= 1'b0;
                end else begin
                    sum       <= nsum;
                    cnt       <= cnt + CW'(1);
                    ovf_run   <= res.ovf;
                end
            end

            if (take && last_beat)
                acc_valid <= 1'b1;
            else if (drain)
                acc_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Bench for booth_mac_accumulator: directed block scenarios plus random traffic,
// scored against an exact-arithmetic block-sum model.
module tb_booth_mac_accumulator;

    localparam int PW    = 65;
    localparam int AW    = 65;
    localparam int BLOCK = 4;
    localparam int CW    = $clog2(BLOCK+1);

    localparam logic signed [127:0] MAXV = (128'sd1 <<< (AW-1)) - 128'sd1;
    localparam logic signed [127:0] MINV = -(128'sd1 <<< (AW-1));

    logic          clk = 1'b0;
    logic          rst;
    logic          prod_valid;
    logic [PW-1:0] prod;
    logic          prod_last;
    logic          prod_ready;
    logic          acc_valid;
    logic [AW-1:0] acc_out;
    logic [CW-1:0] acc_terms;
    logic          acc_ovf;
    logic          acc_ready;

    booth_mac_accumulator #(.PW(PW), .AW(AW), .BLOCK(BLOCK)) dut (
        .clk        (clk),
        .rst        (rst),
        .prod_valid (prod_valid),
        .prod       (prod),
        .prod_last  (prod_last),
        .prod_ready (prod_ready),
        .acc_valid  (acc_valid),
        .acc_out    (acc_out),
        .acc_terms  (acc_terms),
        .acc_ovf    (acc_ovf),
        .acc_ready  (acc_ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: exact running block sum; the visible result slot.
    logic signed [127:0] b_sum;
    int                  b_cnt;
    bit                  b_ovf;
    bit                  m_valid;
    logic [AW-1:0]       m_out;
    int                  m_terms;
    bit                  m_ovf;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        b_sum   = '0;
        b_cnt   = 0;
        b_ovf   = 1'b0;
        m_valid = 1'b0;
        m_out   = '0;
        m_terms = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        prod_valid = 1'b1;
        prod       = PW'(77);
        prod_last  = 1'b1;
        acc_ready  = 1'b0;
        @(posedge clk); #1;
        chk("rst_valid", acc_valid, 0);
        chk("rst_out",   acc_out,   0);
        chk("rst_terms", acc_terms, 0);
        chk("rst_ovf",   acc_ovf,   0);
        chk("rst_pready", prod_ready, 1);
        rst        = 1'b0;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        model_clear();
    endtask

    // One clock: drive inputs, check ready, advance the model, check registered outputs.
    task automatic cycle(input bit v, input logic signed [PW-1:0] p, input bit l, input bit r);
        bit hs, dr, fin;
        prod_valid = v;
        prod       = p;
        prod_last  = l;
        acc_ready  = r;
        #1;
        chk("prod_ready", prod_ready, (!m_valid || r) ? 1 : 0);
        hs  = v && (!m_valid || r);
        dr  = m_valid && r;
        fin = 1'b0;
        @(posedge clk); #1;
        if (hs) begin
            b_sum += p;
            b_cnt++;
            if (b_sum > MAXV || b_sum < MINV) b_ovf = 1'b1;
            fin = l || (b_cnt == BLOCK);
        end
        if (hs && fin) begin
            m_valid = 1'b1;
            m_out   = b_sum[AW-1:0];
            m_terms = b_cnt;
            m_ovf   = b_ovf;
            b_sum   = '0;
            b_cnt   = 0;
            b_ovf   = 1'b0;
        end else if (dr) begin
            m_valid = 1'b0;
        end
        chk("acc_valid", acc_valid, m_valid);
        chk("acc_out",   acc_out,   m_out);
        chk("acc_terms", acc_terms, m_terms);
        chk("acc_ovf",   acc_ovf,   m_ovf);
    endtask

    task automatic expect_res(input string tag, input logic [AW-1:0] v, input int t, input bit o);
        chk({tag, "_valid"}, acc_valid, 1);
        chk({tag, "_out"},   acc_out,   v);
        chk({tag, "_terms"}, acc_terms, t);
        chk({tag, "_ovf"},   acc_ovf,   o);
    endtask

    logic [AW-1:0] big_neg;
    logic [PW-1:0] rp;

    initial begin
        big_neg = '0;
        big_neg[AW-1] = 1'b1;
        model_clear();
        do_reset();

        // Full blocks, back to back.
        cycle(1, 600, 0, 1); cycle(1, 875, 0, 1); cycle(1, -50, 0, 1); cycle(1, 35, 0, 1);
        expect_res("blk1", AW'(1460), 4, 0);
        cycle(1, 0, 0, 1); cycle(1, 180, 0, 1); cycle(1, -60, 0, 1); cycle(1, 600, 0, 1);
        expect_res("blk2", AW'(720), 4, 0);

        // Early termination, then a fresh block.
        cycle(1, 600, 0, 1); cycle(1, -50, 1, 1);
        expect_res("early", AW'(550), 2, 0);
        cycle(1, 10, 0, 1); cycle(1, 20, 1, 1);
        expect_res("restart", AW'(30), 2, 0);

        // Backpressure holds the result and stalls input.
        cycle(1, 600, 0, 1); cycle(1, 875, 1, 1);
        expect_res("bp_first", AW'(1475), 2, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 999, 0, 0);
            chk("bp_hold_out", acc_out, AW'(1475));
            chk("bp_hold_pready", prod_ready, 0);
        end
        cycle(1, -60, 0, 1); cycle(1, 600, 1, 1);
        expect_res("bp_next", AW'(540), 2, 0);

        // Drain and refill on the same edge: no bubble.
        cycle(1, 1, 1, 1); expect_res("stream1", AW'(1), 1, 0);
        cycle(1, 2, 1, 1); expect_res("stream2", AW'(2), 1, 0);
        cycle(1, 3, 1, 1); expect_res("stream3", AW'(3), 1, 0);

        // Signed overflow wraps and flags only its own block.
        for (int i = 0; i < 4; i++) cycle(1, PW'(longint'(1) << 62), 0, 1);
        expect_res("ovf", big_neg, 4, 1);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 1);
        expect_res("ovf_clear", AW'(4), 4, 0);

        // Reset mid-block discards the partial sum.
        cycle(1, 600, 0, 1); cycle(1, 875, 0, 1);
        do_reset();
        cycle(1, 35, 0, 1); cycle(1, 0, 0, 1); cycle(1, 180, 0, 1); cycle(1, -60, 0, 1);
        expect_res("post_rst", AW'(155), 4, 0);

        // Random traffic with random backpressure and early terminations.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0)
                rp = PW'({$urandom(), $urandom(), $urandom()});
            else
                rp = PW'(int'($urandom_range(0, 2000)) - 1000);
            cycle($urandom_range(0, 3) != 0, rp, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_mac_accumulator.md
# booth_mac_accumulator

Downstream consumer of the Radix-4 Booth multiplier. It accepts one signed 65-bit product per handshake and accumulates BLOCK products, or fewer if a block is terminated early by `prod_last`, into a wide signed sum. It publishes each finished sum through a registered output with valid/ready backpressure. The block turns the combinational multiplier into a streaming dot-product / MAC stage.

## Interface
- `PW`, 65: product width; matches multiplier output, treated as signed two's complement.
- `AW`, 72: accumulator width; constraint AW ≥ PW.
- `BLOCK`, 8: products per block; constraint BLOCK ≥ 1.
- `CW`, $clog2(BLOCK+1): term-counter width, derived.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `prod_valid`  in  1  product beat offered.
- `prod`  in  PW  signed product from multiplier.
- `prod_last`  in  1  beat closes current block early; sampled only on handshake.
- `prod_ready`  out  1  stage can accept a beat.
- `acc_valid`  out  1  output register holds a finished sum.
- `acc_out`  out  AW  finished block sum.
- `acc_terms`  out  CW  number of products in `acc_out`'s block (1..BLOCK).
- `acc_ovf`  out  1  sticky per-block signed-overflow flag for `acc_out`.
- `acc_ready`  in  1  downstream accepts output.

## Operation
- Handshake: input transfer when `prod_valid && prod_ready`; output transfer when `acc_valid && acc_ready`.
- `prod_ready = !acc_valid || acc_ready`.
  - Purely state/ready based; never depends on `prod` or `prod_last`.
- Internal running state: `sum` (AW, signed), `cnt` (CW), `ovf_run` (1).
- On input handshake, `nsum = sum + sext(prod)` at AW bits, wrapping.
  - Overflow occurs when `sum` and `sext(prod)` have equal sign and `nsum` sign differs. It sets the overflow bit for this block.
- A handshake is *final* when `cnt == BLOCK-1` or `prod_last == 1`. On a final beat:
  - `acc_out ← nsum`
  - `acc_terms ← cnt+1`
  - `acc_ovf ← ovf_run | overflow-this-beat`
  - `acc_valid ← 1`
  - `sum ← 0`, `cnt ← 0`, `ovf_run ← 0`
- Non-final handshake: `sum ← nsum`, `cnt ← cnt+1`, `ovf_run` updated.
- Output drain without a new final beat: `acc_valid ← 0`. `acc_out`, `acc_terms` and `acc_ovf` hold their last values.
- Simultaneous drain and final beat: the new result loads and `acc_valid` stays 1. No bubble and no loss.
- While `acc_valid && !acc_ready`, `prod_ready = 0`. This applies even to non-final beats, which stall as well. The running `sum` is untouched.
- Two-state view:
  - EMPTY (`acc_valid=0`) → FULL on a final beat.
  - FULL → EMPTY on a drain without a final beat.
  - FULL → FULL on a drain with a final beat, or with no drain.
- `BLOCK=1`: every beat is final.

## Timing
- Latency: the final handshake in cycle N gives `acc_valid=1` with the new `acc_out` in cycle N+1. Outputs are registered with no combinational path from `prod` to `acc_*`.
- Throughput: one product per cycle sustained when `acc_ready` is held at 1.
- `prod_ready` is combinational from `acc_valid` (register) and `acc_ready` only.
- Reset, which overrides everything in the same edge:
  - `sum=0`, `cnt=0`, `ovf_run=0`
  - `acc_valid=0`, `acc_out=0`, `acc_terms=0`, `acc_ovf=0`
  - After reset `prod_ready=1`.
- Reset mid-block discards the partial sum and any held result; no output is produced for the interrupted block.
- `prod` and `prod_last` are ignored when no handshake occurs.

## Test plan
- BLOCK=4, `acc_ready=1`, back-to-back products 600, 875, −50, 35 → one cycle after the 4th beat: `acc_valid=1`, `acc_out=1460`, `acc_terms=4`, `acc_ovf=0`. Next block 0, 180, −60, 600 → `acc_out=720`.
- BLOCK=8, products 600, −50 with `prod_last=1` on the second beat → `acc_out=550`, `acc_terms=2`. The following block restarts from 0.
- Backpressure: BLOCK=2, hold `acc_ready=0` after the first result (1475). Expect:
  - `prod_ready=0` and `acc_out` stable at 1475 for 5 cycles.
  - Release `acc_ready` → the same cycle `prod_ready=1`; the next block (−60, 600) yields 540 with no lost or duplicated beat.
- Simultaneous drain + final beat: BLOCK=1, `acc_ready=1`, continuous products 1, 2, 3 → `acc_valid` held at 1 for 3 consecutive cycles with `acc_out` 1, 2, 3.
- Overflow: AW=65, BLOCK=4, four products of +2^62 → `acc_out` = −2^64 (wrapped), `acc_ovf=1`. The next block of four 1s gives `acc_out=4`, `acc_ovf=0`.
- Reset mid-block: BLOCK=4, two beats (600, 875), assert `rst` one cycle. Then feed 35, 0, 180, −60 → `acc_out=155` (no carry-over), `acc_terms=4`. All outputs read 0 during and immediately after reset.
